// File: rtl/nf_axis_pkt_sink.sv
// AXI4-Stream packet sink: checks sequence, payload pattern, tkeep shape and length, keeps running stats.
// Optional macro NF_SINK_THROTTLE_EN adds LFSR-driven pseudo-random tready backpressure.
module nf_axis_pkt_sink #(
   parameter int C_S_AXIS_DATA_WIDTH  = 1024,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int THROTTLE_PERCENT     = 50
) (
   input  logic                              axis_aclk,
   input  logic                              axis_rst,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,
   output logic [31:0]                       pkt_count,
   output logic [63:0]                       byte_count,
   output logic [31:0]                       err_count,
   output logic [2:0]                        last_err,
   output logic                              err_pulse,
   input  logic                              clear_stats
);

   localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
   localparam int LANES  = C_S_AXIS_DATA_WIDTH / 32;
   localparam int CNT_W  = $clog2(KEEP_W + 1);

   typedef enum logic {IDLE, PKT} state_t;

   state_t        state_reg;
   logic [15:0]   exp_seq_reg;
   logic [15:0]   seq_reg;
   logic [15:0]   len_reg;
   logic [15:0]   idx_reg;
   logic [31:0]   acc_reg;
   logic          seq_err_reg;
   logic          data_err_reg;
   logic          keep_err_reg;
   logic [31:0]   pkt_count_reg;
   logic [63:0]   byte_count_reg;
   logic [31:0]   err_count_reg;
   logic [2:0]    last_err_reg;
   logic          err_pulse_reg;

   logic              xfer;
   logic              first;
   logic [15:0]       rx_seq;
   logic [15:0]       cur_seq;
   logic [15:0]       cur_idx;
   logic [15:0]       cur_len;
   logic [LANES-1:0]  lane_bad;
   logic              data_bad;
   logic              keep_bad;
   logic              seq_bad;
   logic              len_bad;
   logic [CNT_W-1:0]  beat_bytes;
   logic [31:0]       tot_bytes;
   logic [KEEP_W-1:0] keep_plus;
   logic              s_err;
   logic              d_err;
   logic              k_err;
   logic [2:0]        err_code;
   logic [64:0]       byte_sum;
   logic              unused_bits;

   assign unused_bits = ^s_axis_tuser;

`ifdef NF_SINK_THROTTLE_EN
   logic [15:0] lfsr_reg;
   logic        throttle;

   // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
   always_ff @(posedge axis_aclk) begin
      if (axis_rst)
         lfsr_reg <= 16'hACE1;
      else
         lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
   end

   assign throttle      = (({25'd0, lfsr_reg[6:0]} % 32'd100) < 32'(THROTTLE_PERCENT));
   assign s_axis_tready = ~axis_rst & ~throttle;
`else
   assign s_axis_tready = ~axis_rst;
`endif

   assign xfer    = s_axis_tvalid & s_axis_tready;
   assign first   = (state_reg == IDLE);
   assign rx_seq  = s_axis_tdata[31:16];
   assign cur_seq = first ? rx_seq : seq_reg;
   assign cur_idx = first ? 16'd0 : idx_reg;
   assign cur_len = first ? s_axis_tuser[15:0] : len_reg;

   // Only lanes whose four keep bits are all set carry checkable payload.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_bad[gi] = (&s_axis_tkeep[4*gi +: 4]) &&
                               (s_axis_tdata[32*gi +: 32] != {cur_seq, cur_idx});
      end
   endgenerate

   always_comb begin
      beat_bytes = '0;
      for (int i = 0; i < KEEP_W; i++)
         beat_bytes = beat_bytes + CNT_W'(s_axis_tkeep[i]);
   end

   // A contiguous LSB-aligned mask plus one has no bits in common with itself.
   assign keep_plus = s_axis_tkeep + KEEP_W'(1);
   assign keep_bad  = s_axis_tlast ? ((s_axis_tkeep == '0) || ((s_axis_tkeep & keep_plus) != '0))
                                   : ~(&s_axis_tkeep);
   assign data_bad  = |lane_bad;
   assign seq_bad   = first && (rx_seq != exp_seq_reg);
   assign tot_bytes = (first ? 32'd0 : acc_reg) + 32'(beat_bytes);
   assign len_bad   = (tot_bytes != {16'd0, cur_len});

   assign s_err = (~first & seq_err_reg) | seq_bad;
   assign d_err = (~first & data_err_reg) | data_bad;
   assign k_err = (~first & keep_err_reg) | keep_bad;

   always_comb begin
      err_code = 3'd0;
      if (len_bad)
         err_code = 3'd4;
      else if (k_err)
         err_code = 3'd3;
      else if (d_err)
         err_code = 3'd2;
      else if (s_err)
         err_code = 3'd1;
   end

   assign byte_sum = {1'b0, byte_count_reg} + {33'd0, tot_bytes};

   always_ff @(posedge axis_aclk) begin
      if (axis_rst) begin
         state_reg      <= IDLE;
         exp_seq_reg    <= 16'd0;
         seq_reg        <= 16'd0;
         len_reg        <= 16'd0;
         idx_reg        <= 16'd0;
         acc_reg        <= 32'd0;
         seq_err_reg    <= 1'b0;
         data_err_reg   <= 1'b0;
         keep_err_reg   <= 1'b0;
         pkt_count_reg  <= 32'd0;
         byte_count_reg <= 64'd0;
         err_count_reg  <= 32'd0;
         last_err_reg   <= 3'd0;
         err_pulse_reg  <= 1'b0;
      end else begin
         err_pulse_reg <= 1'b0;
         if (xfer) begin
            if (first) begin
               exp_seq_reg <= rx_seq + 16'd1;
               seq_reg     <= rx_seq;
               len_reg     <= s_axis_tuser[15:0];
            end
            if (s_axis_tlast) begin
               state_reg <= IDLE;
            end else begin
               state_reg    <= PKT;
               idx_reg      <= cur_idx + 16'd1;
               acc_reg      <= tot_bytes;
               seq_err_reg  <= s_err;
               data_err_reg <= d_err;
               keep_err_reg <= k_err;
            end
         end
         // Clearing takes precedence over a packet completing in the same cycle.
         if (clear_stats) begin
            pkt_count_reg  <= 32'd0;
            byte_count_reg <= 64'd0;
            err_count_reg  <= 32'd0;
            last_err_reg   <= 3'd0;
         end else if (xfer && s_axis_tlast) begin
            if (pkt_count_reg != '1)
               pkt_count_reg <= pkt_count_reg + 32'd1;
            byte_count_reg <= byte_sum[64] ? '1 : byte_sum[63:0];
            if (err_code != 3'd0) begin
               if (err_count_reg != '1)
                  err_count_reg <= err_count_reg + 32'd1;
               last_err_reg  <= err_code;
               err_pulse_reg <= 1'b1;
            end
         end
      end
   end

   assign pkt_count  = pkt_count_reg;
   assign byte_count = byte_count_reg;
   assign err_count  = err_count_reg;
   assign last_err   = last_err_reg;
   assign err_pulse  = err_pulse_reg;

endmodule

// File: tb/tb_nf_axis_pkt_sink.sv
// Scoreboard bench for nf_axis_pkt_sink: directed packets push expected stats, a monitor compares on each completion.
module tb_nf_axis_pkt_sink;

   localparam int DW  = 128;
   localparam int TUW = 32;
   localparam int KW  = DW / 8;

   logic            axis_aclk = 1'b0;
   logic            axis_rst  = 1'b1;
   logic [DW-1:0]   s_axis_tdata  = '0;
   logic [KW-1:0]   s_axis_tkeep  = '0;
   logic [TUW-1:0]  s_axis_tuser  = '0;
   logic            s_axis_tvalid = 1'b0;
   logic            s_axis_tlast  = 1'b0;
   logic            s_axis_tready;
   logic [31:0]     pkt_count;
   logic [63:0]     byte_count;
   logic [31:0]     err_count;
   logic [2:0]      last_err;
   logic            err_pulse;
   logic            clear_stats = 1'b0;

   always #5 axis_aclk = ~axis_aclk;

   nf_axis_pkt_sink #(
      .C_S_AXIS_DATA_WIDTH (DW),
      .C_S_AXIS_TUSER_WIDTH(TUW),
      .THROTTLE_PERCENT    (50)
   ) dut (
      .axis_aclk    (axis_aclk),
      .axis_rst     (axis_rst),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tkeep (s_axis_tkeep),
      .s_axis_tuser (s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .pkt_count    (pkt_count),
      .byte_count   (byte_count),
      .err_count    (err_count),
      .last_err     (last_err),
      .err_pulse    (err_pulse),
      .clear_stats  (clear_stats)
   );

   typedef struct packed {
      logic [31:0] pkts;
      logic [63:0] bytes;
      logic [31:0] errs;
      logic [2:0]  code;
      logic        pulse;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   task automatic expect_stats(input int p, input int b, input int e, input int c, input int pl);
      exp_t x;
      x.pkts  = 32'(p);
      x.bytes = 64'(b);
      x.errs  = 32'(e);
      x.code  = 3'(c);
      x.pulse = pl[0];
      exp_q.push_back(x);
   endtask

   // Monitor: a non-zero change of pkt_count marks a completed packet.
   initial begin
      logic [31:0] prev;
      exp_t        e;
      prev = '0;
      forever begin
         @(negedge axis_aclk);
         if (axis_rst) begin
            prev = '0;
         end else if (pkt_count != prev) begin
            prev = pkt_count;
            if (pkt_count != 0) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pkt: actual pkt_count %0d required no completion", pkt_count);
               end else begin
                  e = exp_q.pop_front();
                  $display("txn: pkt_count=%0d byte_count=%0d err_count=%0d last_err=%0d err_pulse=%0d",
                           pkt_count, byte_count, err_count, last_err, err_pulse);
                  chk("pkt_count",  64'(pkt_count),  64'(e.pkts));
                  chk("byte_count", byte_count,      e.bytes);
                  chk("err_count",  64'(err_count),  64'(e.errs));
                  chk("last_err",   64'(last_err),   64'(e.code));
                  chk("err_pulse",  64'(err_pulse),  64'(e.pulse));
               end
            end
         end
      end
   end

   // Drives one packet; nbytes sets beat count and default keep, overrides of 0 mean automatic.
   task automatic send_pkt(input logic [15:0] sq, input logic [15:0] len, input int nbytes,
                           input int bad_beat, input int bad_lane,
                           input logic [KW-1:0] first_keep, input logic [KW-1:0] last_keep,
                           input int max_beats);
      int nb;
      int rem;
      int t;
      nb = (nbytes + KW - 1) / KW;
      for (int b = 0; b < nb && b < max_beats; b++) begin
         @(negedge axis_aclk);
         for (int l = 0; l < DW / 32; l++)
            s_axis_tdata[32*l +: 32] = {sq, 16'(b)};
         if (b == bad_beat)
            s_axis_tdata[32*bad_lane +: 32] = s_axis_tdata[32*bad_lane +: 32] ^ 32'h1;
         rem = nbytes - KW * b;
         s_axis_tkeep = (rem >= KW) ? '1 : KW'((17'd1 << rem) - 17'd1);
         if (b == 0 && first_keep != '0)
            s_axis_tkeep = first_keep;
         if (b == nb - 1 && last_keep != '0)
            s_axis_tkeep = last_keep;
         s_axis_tuser  = TUW'(len);
         s_axis_tlast  = (b == nb - 1);
         s_axis_tvalid = 1'b1;
         t = 0;
         while (!s_axis_tready && t < 100) begin
            @(negedge axis_aclk);
            t++;
         end
         if (t == 100) begin
            $display("FAIL tready_timeout: actual tready 0 required 1");
            $fatal(1, "tready never asserted");
         end
         @(posedge axis_aclk);
      end
      @(negedge axis_aclk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 40) begin
         @(negedge axis_aclk);
         t++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: actual %0d pending completions required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pkt_count"},  64'(pkt_count), 64'd0);
      chk({tag, "_byte_count"}, byte_count,     64'd0);
      chk({tag, "_err_count"},  64'(err_count), 64'd0);
      chk({tag, "_last_err"},   64'(last_err),  64'd0);
   endtask

   task automatic do_clear();
      @(negedge axis_aclk);
      clear_stats = 1'b1;
      @(negedge axis_aclk);
      clear_stats = 1'b0;
      chk_zero("clear");
   endtask

   initial begin
      repeat (3) @(negedge axis_aclk);
      chk("rst_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_err_pulse", 64'(err_pulse), 64'd0);
      chk_zero("rst");
      axis_rst = 1'b0;
      @(negedge axis_aclk);
      chk("run_tready", 64'(s_axis_tready), 64'd1);

      // Three clean 200-byte packets, seq 0..2.
      expect_stats(1, 200, 0, 0, 0); send_pkt(16'd0, 16'd200, 200, -1, 0, '0, '0, 99);
      expect_stats(2, 400, 0, 0, 0); send_pkt(16'd1, 16'd200, 200, -1, 0, '0, '0, 99);
      expect_stats(3, 600, 0, 0, 0); send_pkt(16'd2, 16'd200, 200, -1, 0, '0, '0, 99);
      wait_drain("drain_clean");
      do_clear();

      // Sequence jump 3 -> 5, then 6 is accepted cleanly.
      expect_stats(1, 64, 1, 1, 1);  send_pkt(16'd5, 16'd64, 64, -1, 0, '0, '0, 99);
      expect_stats(2, 128, 1, 1, 0); send_pkt(16'd6, 16'd64, 64, -1, 0, '0, '0, 99);
      wait_drain("drain_seq");
      do_clear();

      // Non-contiguous last keep 0x0F0F with matching length (16 + 8 bytes).
      expect_stats(1, 24, 1, 3, 1);   send_pkt(16'd7, 16'd24, 32, -1, 0, '0, 16'h0F0F, 99);
      // Length 256 declared, 250 delivered.
      expect_stats(2, 274, 2, 4, 1);  send_pkt(16'd8, 16'd256, 250, -1, 0, '0, '0, 99);
      // Corrupted lane 1 of beat 1.
      expect_stats(3, 322, 3, 2, 1);  send_pkt(16'd9, 16'd48, 48, 1, 1, '0, '0, 99);
      // SEQ + DATA + LEN together: highest code wins, counted once.
      expect_stats(4, 354, 4, 4, 1);  send_pkt(16'd20, 16'd40, 32, 0, 3, '0, '0, 99);
      // Partial keep on a non-last beat (15 + 16 bytes).
      expect_stats(5, 385, 5, 3, 1);  send_pkt(16'd21, 16'd31, 32, -1, 0, 16'hFFFE, '0, 99);
      // Single-beat clean packet.
      expect_stats(6, 401, 5, 3, 0);  send_pkt(16'd22, 16'd16, 16, -1, 0, '0, '0, 99);
      wait_drain("drain_err");

      // Clear coincident with a tlast transfer: not counted, tracking continues.
      @(negedge axis_aclk);
      clear_stats = 1'b1;
      send_pkt(16'd23, 16'd16, 16, -1, 0, '0, '0, 99);
      clear_stats = 1'b0;
      chk_zero("clear_last");
      expect_stats(1, 16, 0, 0, 0);   send_pkt(16'd24, 16'd16, 16, -1, 0, '0, '0, 99);
      wait_drain("drain_clear_last");

      // Reset after two beats of a three-beat packet.
      send_pkt(16'd25, 16'd48, 48, -1, 0, '0, '0, 2);
      axis_rst = 1'b1;
      @(negedge axis_aclk);
      @(negedge axis_aclk);
      chk_zero("midrst");
      axis_rst = 1'b0;
      expect_stats(1, 48, 0, 0, 0);   send_pkt(16'd0, 16'd48, 48, -1, 0, '0, '0, 99);
      wait_drain("drain_midrst");

      repeat (3) @(negedge axis_aclk);
      chk("final_err_pulse", 64'(err_pulse), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
